// File: rtl/fft_frame_ctrl.sv
// Frame controller for the 16-point combinational FFT: fills a 16-sample frame, launches the core,
// captures its results after CORE_LAT cycles and streams them out in natural bin order.
module fft_frame_ctrl #(
   parameter int unsigned CORE_LAT = 4,
   parameter bit          BITREV   = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [15:0]  in_data,
   output logic         in_ready,
   output logic [511:0] core_in,
   output logic         core_start,
   input  logic [511:0] core_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic [3:0]   out_idx,
   output logic         out_last,
   output logic         busy
);
   localparam logic [3:0] LatLast = 4'(CORE_LAT);

   logic [15:0] buf_q [16];
   logic [31:0] res_q [16];
   logic [3:0]  wr_cnt_q, rd_cnt_q, lat_cnt_q;
   logic        buf_full_q, calc_q, res_valid_q;
   logic        accept, launch, capture, beat;
   logic [3:0]  rd_slot;

   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   always_comb begin
      accept  = in_valid && !buf_full_q;
      launch  = buf_full_q && !calc_q && !res_valid_q;
      capture = calc_q && (lat_cnt_q == LatLast);
      beat    = res_valid_q && out_ready;
      rd_slot = BITREV ? bitrev4(rd_cnt_q) : rd_cnt_q;
   end

   // Imag field of every input slot is zero; only the real half is stored.
   for (genvar k = 0; k < 16; k++) begin : g_slot
      assign core_in[32*k +: 32] = {buf_q[k], 16'h0000};
   end

   assign in_ready   = !buf_full_q;
   assign core_start = launch;
   assign out_valid  = res_valid_q;
   assign out_idx    = rd_cnt_q;
   assign out_data   = res_q[rd_slot];
   assign out_last   = res_valid_q && (rd_cnt_q == 4'hf);
   assign busy       = buf_full_q || calc_q || res_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) buf_q[k] <= '0;
      end else if (accept) begin
         buf_q[wr_cnt_q] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) res_q[k] <= '0;
      end else if (capture) begin
         for (int k = 0; k < 16; k++) res_q[k] <= core_out[32*k +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         lat_cnt_q   <= '0;
         buf_full_q  <= 1'b0;
         calc_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            wr_cnt_q <= wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'hf) buf_full_q <= 1'b1;
         end
         if (launch) begin
            calc_q    <= 1'b1;
            lat_cnt_q <= 4'd1;
         end else if (calc_q) begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
         end
         // Releasing the buffer here lets the next frame fill while results drain.
         if (capture) begin
            calc_q      <= 1'b0;
            buf_full_q  <= 1'b0;
            res_valid_q <= 1'b1;
         end
         if (beat) begin
            rd_cnt_q <= rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'hf) res_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: two instances (bit-reversed and direct order) with a loopback core stub,
// checked every cycle against a queue-based frame model.
module tb_fft_frame_ctrl;
   localparam int unsigned LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, out_ready;
   logic [15:0]  in_data;
   logic [511:0] core_in_a, core_in_b;
   logic         in_ready_a, in_ready_b, core_start_a, core_start_b;
   logic         out_valid_a, out_valid_b, out_last_a, out_last_b, busy_a, busy_b;
   logic [31:0]  out_data_a, out_data_b;
   logic [3:0]   out_idx_a, out_idx_b;

   fft_frame_ctrl #(.CORE_LAT(LAT), .BITREV(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
      .core_in(core_in_a), .core_start(core_start_a), .core_out(core_in_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_idx(out_idx_a),
      .out_last(out_last_a), .busy(busy_a)
   );

   fft_frame_ctrl #(.CORE_LAT(LAT), .BITREV(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
      .core_in(core_in_b), .core_start(core_start_b), .core_out(core_in_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_idx(out_idx_b),
      .out_last(out_last_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Model: frame buffer contents, fill level, compute window and pending result beats.
   logic [15:0] m_buf [16];
   int          m_cnt, m_cap_at;
   bit          m_full, m_calc, m_fresh;
   logic [31:0] m_res_a [$];
   logic [31:0] m_res_b [$];
   logic [15:0] src [$];

   function automatic int rev4(input int k);
      int r = 0;
      for (int b = 0; b < 4; b++) if ((k & (1 << b)) != 0) r |= 1 << (3 - b);
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 16; k++) m_buf[k] = '0;
      m_cnt = 0; m_cap_at = 0; m_full = 0; m_calc = 0; m_fresh = 1;
      m_res_a.delete(); m_res_b.delete(); src.delete();
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic check_inst(input string nm, input logic rdy, input logic [511:0] ci,
                             input logic st, input logic ov, input logic [31:0] od,
                             input logic [3:0] oi, input logic ol, input logic bz,
                             input logic [31:0] head);
      logic [511:0] ecore;
      int           sz = m_res_a.size();
      logic [3:0]   eidx = (sz > 0) ? 4'(16 - sz) : 4'd0;
      for (int k = 0; k < 16; k++) ecore[32*k +: 32] = {m_buf[k], 16'h0000};
      chk({nm, ".in_ready"},   512'(rdy), 512'(!m_full));
      chk({nm, ".core_in"},    ci, ecore);
      chk({nm, ".core_start"}, 512'(st), 512'(m_full && !m_calc && sz == 0));
      chk({nm, ".out_valid"},  512'(ov), 512'(sz > 0));
      chk({nm, ".out_idx"},    512'(oi), 512'(eidx));
      chk({nm, ".out_last"},   512'(ol), 512'(sz == 1));
      chk({nm, ".busy"},       512'(bz), 512'(m_full || m_calc || sz > 0));
      if (sz > 0) chk({nm, ".out_data"}, 512'(od), 512'(head));
      else if (m_fresh) chk({nm, ".out_data_rst"}, 512'(od), 512'd0);
   endtask

   task automatic check_all();
      check_inst("a", in_ready_a, core_in_a, core_start_a, out_valid_a, out_data_a, out_idx_a,
                 out_last_a, busy_a, (m_res_a.size() > 0) ? m_res_a[0] : 32'd0);
      check_inst("b", in_ready_b, core_in_b, core_start_b, out_valid_b, out_data_b, out_idx_b,
                 out_last_b, busy_b, (m_res_b.size() > 0) ? m_res_b[0] : 32'd0);
   endtask

   // vmode: 0 always, 1 one cycle in three, 2 random. rmode: 0 ready, 1 pattern 1,0,0,1,
   // 2 random, 3 stalled.
   task automatic step(input int vmode, input int rmode);
      bit gate, acc, start, cap, pop;
      case (vmode)
         0:       gate = 1'b1;
         1:       gate = (cyc % 3) == 0;
         default: gate = $urandom_range(0, 1) == 1;
      endcase
      in_valid = (src.size() > 0) && gate;
      in_data  = (src.size() > 0) ? src[0] : 16'($urandom);
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         2:       out_ready = $urandom_range(0, 1) == 1;
         default: out_ready = 1'b0;
      endcase
      #1;
      check_all();
      acc   = in_valid && !m_full;
      start = m_full && !m_calc && m_res_a.size() == 0;
      cap   = m_calc && cyc == m_cap_at;
      pop   = out_ready && m_res_a.size() > 0;
      if (pop) begin
         void'(m_res_a.pop_front());
         void'(m_res_b.pop_front());
      end
      if (cap) begin
         for (int k = 0; k < 16; k++) begin
            m_res_a.push_back({m_buf[rev4(k)], 16'h0000});
            m_res_b.push_back({m_buf[k], 16'h0000});
         end
         m_calc = 0; m_full = 0; m_fresh = 0;
      end else if (start) begin
         m_calc = 1;
         m_cap_at = cyc + LAT;
      end
      if (acc) begin
         m_buf[m_cnt] = in_data;
         void'(src.pop_front());
         m_cnt++;
         if (m_cnt == 16) begin
            m_cnt = 0;
            m_full = 1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic bit model_idle();
      return src.size() == 0 && !m_full && !m_calc && m_res_a.size() == 0;
   endfunction

   task automatic run(input int vmode, input int rmode, input int maxc, input bit want_idle);
      int n = 0;
      while (n < maxc && !(want_idle && model_idle())) begin
         step(vmode, rmode);
         n++;
      end
      if (want_idle) chk("phase_idle", 512'({busy_a, busy_b}), 512'd0);
   endtask

   task automatic apply_reset(input int ncyc);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (ncyc) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      apply_reset(2);

      for (int i = 1; i <= 16; i++) src.push_back(16'(i));
      run(0, 0, 200, 1);

      for (int i = 0; i < 16; i++) src.push_back(16'($urandom));
      run(0, 1, 300, 1);

      // Second frame arrives while the first is stalled at the sink.
      for (int i = 0; i < 32; i++) src.push_back(16'($urandom));
      run(0, 3, 60, 0);
      run(0, 0, 300, 1);

      for (int i = 0; i < 16; i++) src.push_back(16'($urandom));
      run(1, 2, 400, 1);

      for (int i = 0; i < 7; i++) src.push_back(16'($urandom));
      run(0, 0, 7, 0);
      apply_reset(2);
      for (int i = 0; i < 16; i++) src.push_back(16'(16'h0100 + i));
      run(0, 0, 200, 1);

      for (int i = 0; i < 64; i++) src.push_back(16'($urandom));
      run(2, 2, 3000, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequences the combinational 16-point FFT datapath (stage1..stage4 butterfly chain) for one frame at a time.
- Collects 16 serial real samples into a frame buffer and presents them in parallel to the FFT core.
- Waits a fixed core latency, captures the 16 complex results, then streams them out one per cycle in natural frequency order with a valid/ready handshake.
- Sits between the FIR output stream and the downstream result sink.

Parameters:
- CORE_LAT, 4, cycles from core_start to core_out sampled valid (legal range 1..15)
- BITREV, 1, 1: core_out slots are bit-reversed and are reordered on output; 0: output slot k directly

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_data  in  16  signed real sample, same fixed-point format as the core real field
- in_ready  out  1  controller can accept a sample this cycle
- core_in  out  512  frame to FFT core; slot k at [32k+31:32k] = {real[15:0], imag[15:0]}
- core_start  out  1  one-cycle pulse, frame on core_in is launched
- core_out  in  512  FFT core result, same slot packing
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts beat
- out_data  out  32  {real, imag} of frequency bin out_idx
- out_idx  out  4  frequency bin index 0..15
- out_last  out  1  high on bin 15 beat
- busy  out  1  frame buffer full or compute in progress or result pending

Behaviour:
- Reset (async, rst_n=0): wr_cnt=0, rd_cnt=0, lat_cnt=0, buf_full=0, calc=0, res_valid=0.
- Reset outputs: in_ready=1, core_start=0, out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0.
- Frame buffer and result registers reset to 0.
- Input side:
  - in_ready = !buf_full.
  - On in_valid&&in_ready: buffer slot wr_cnt <= {in_data,16'h0000}; wr_cnt increments, wrapping 15->0.
  - Accepting at wr_cnt==15 sets buf_full; in_ready drops the next cycle.
- core_in is driven continuously from the frame buffer. The buffer is frozen while buf_full=1, so core_in is stable for the whole compute.
- Launch:
  - Condition: buf_full && !calc && !res_valid.
  - core_start=1 for exactly that cycle; calc<=1; lat_cnt<=1.
- Compute:
  - While calc, lat_cnt increments each cycle.
  - In the cycle with lat_cnt==CORE_LAT, core_out is captured into the result registers, with calc<=0, buf_full<=0 and res_valid<=1.
  - Capture therefore occurs CORE_LAT cycles after the core_start cycle.
  - in_ready rises the cycle after capture, so the next frame fills while results drain.
- Output side:
  - out_valid = res_valid.
  - out_idx = rd_cnt.
  - out_data = result slot bitrev4(rd_cnt) if BITREV=1, else slot rd_cnt.
  - out_last = res_valid && rd_cnt==15.
  - On out_valid&&out_ready, rd_cnt increments.
  - On the last beat: rd_cnt<=0 and res_valid<=0. A waiting full buffer launches the following cycle, with no same-cycle bypass.
  - With out_ready=0, out_data/out_idx hold stable.
- State summary:
  - FILL: !buf_full.
  - WAIT: buf_full && !calc && res_valid.
  - CALC: calc.
  - Draining (res_valid) is orthogonal to FILL.
- busy = buf_full || calc || res_valid.
- Arithmetic: no arithmetic beyond counters; imag field of every input slot is 0; no saturation or scaling in this block.
- Mid-operation reset (rst_n asserted during fill, compute or drain): discards all partial frames immediately; no core_start or out_valid is emitted after reset release until a new full frame arrives.
- in_valid while in_ready=0: the sample is ignored (not stored) and the sender must hold it.

Test Plan:
- Reset then 16 samples 0x0001..0x0010 back-to-back, core stub core_out=core_in, BITREV=1, CORE_LAT=4, out_ready=1:
  - core_start one cycle after 16th accept.
  - Capture 4 cycles later.
  - Beats out_idx 0..15 with out_data 0x00010000, 0x00090000, 0x00050000, ..., 0x00100000 (bin k = sample bitrev(k)+1).
  - out_last only on idx 15.
- BITREV=0, same stimulus: out_data for bin k = {k+1,16'h0}.
- out_ready toggled 1,0,0,1 during drain: out_idx/out_data held while ready=0; no beat skipped or duplicated; 16 beats total.
- Second frame streamed during drain with out_ready=0 held:
  - in_ready falls after 16 samples.
  - No core_start until the cycle after the first frame's out_last handshake.
  - Second frame results are correct.
- in_valid pulsed with gaps (1 of 3 cycles): exactly 16 samples captured in order; core_start only after the 16th accepted sample.
- rst_n low for 2 cycles after 7 samples, then 16 fresh samples 0x0100..0x010F: first out_data=0x01000000; no stale data; no extra core_start.
